ycc_stream_ctrl: RTL
====================

# ycc_stream_ctrl

Sequencer in front of the `ycrcb2rgb` converter in the video-capture path. It accepts 10-bit Y/Cr/Cb pixels from the NTSC decoder front end and tracks active-window x/y position. It feeds the converter, delays valid and address sideband to match the converter's pipeline, and buffers the RGB results in a small FIFO. From there it issues write requests to the frame-buffer memory arbiter.

## Interface
- `H_ACTIVE`, 640, active pixels per line
- `V_ACTIVE`, 480, active lines per frame
- `CONV_LAT`, 3, converter input-to-output latency in clocks; fixed by the converter
- `FIFO_DEPTH`, 4, output FIFO entries (power of 2)
- `ADDR_W`, 19, frame-buffer word-address width
- `clk` in 1: single clock; `rst` in 1: synchronous, active-high reset
- `enable` in 1: capture enable, sampled only in IDLE
- `frame_start` in 1: one-cycle pulse, start of frame
- `line_start` in 1: one-cycle pulse, start of line
- `pix_valid` in 1: pixel strobe
- `pix_y`, `pix_cr`, `pix_cb` in 10 each: pixel components
- `cv_y`, `cv_cr`, `cv_cb` out 10 each: converter inputs, registered
- `cv_r`, `cv_g`, `cv_b` in 8 each: converter outputs
- `wr_valid` out 1: write request valid
- `wr_ready` in 1: write request accepted
- `wr_addr` out ADDR_W: write address
- `wr_data` out 24: write data `{R,G,B}`
- `frame_done` out 1: one-cycle pulse after the last pixel of a frame is written
- `overflow` out 1: sticky flag, set on any FIFO drop; cleared by `frame_start` or `rst`
- `drop_cnt` out 16: saturating count of dropped pixels; cleared by `rst` only
- `busy` out 1: high in any state other than IDLE

## Operation
- **States:** IDLE, ACTIVE, FLUSH.
  - IDLE → ACTIVE when `enable && frame_start`.
  - ACTIVE → FLUSH in the cycle pixel (H_ACTIVE-1, V_ACTIVE-1) is accepted.
  - FLUSH → IDLE once the delay line and FIFO are both empty; `frame_done` pulses on that transition.
- **Frame and line counters:**
  - `frame_start` in ACTIVE sets x=0, y=0 (restart). Entries already in flight are still written.
  - `line_start`: x←0; y←y+1 only if x≠0.
  - A pixel is accepted when `pix_valid` is high in ACTIVE, x<H_ACTIVE and y<V_ACTIVE; accepting increments x. All other pixels are ignored and are not counted as drops.
- **Address generation:** incremental, with no multiplier. `row_base += H_ACTIVE` whenever y increments; address = row_base + x.
- **Converter drive:**
  - Accepted pixel: `cv_*` ← `pix_*`.
  - Otherwise `cv_*` ← black (Y=64, Cr=512, Cb=512), so that idle converter output is 0.
- **Sideband delay line:** a CONV_LAT-stage shift register of {valid, addr}, aligned with the `cv_*` register output. At the end of the line, valid entries push `{cv_r,cv_g,cv_b}` plus the address into the FIFO.
- **FIFO overflow:** a push into a full FIFO is discarded. The discard sets `overflow` and increments `drop_cnt` (saturating at 0xFFFF). The converter cannot stall, so input is never back-pressured.
- **Write handshake:**
  - A transfer occurs when `wr_valid && wr_ready`.
  - `wr_valid`, `wr_addr` and `wr_data` stay stable while `wr_valid && !wr_ready`.
  - A simultaneous push and pop when full is legal: the pop frees the slot and the push is kept.

## Timing
- **Reset values:** every output is 0 except `cv_y`=64 and `cv_cr`=`cv_cb`=512. State is IDLE. The FIFO and delay line are emptied.
- **Mid-frame `rst`:** in-flight pixels are lost, and `wr_valid` is 0 in the cycle after `rst` is sampled.
- **Latency:**
  - Pixel accepted at edge t → `cv_*` valid after t.
  - RGB pushed at edge t+CONV_LAT+1.
  - `wr_valid` high after edge t+CONV_LAT+1, i.e. 4 clocks with an empty FIFO.
- **Throughput:** one pixel per clock sustained while `wr_ready` is held high.
- **`frame_done` timing:** asserts in the cycle after the final `wr_valid && wr_ready` of the frame.

## Structure
- Package `ycc_pkg` holds:
  - the state enum `ycc_state_t`;
  - the black constants `YCC_BLACK_Y` = 10'd64 and `YCC_BLACK_C` = 10'd512;
  - `CONV_LAT_DEF` = 3;
  - the packed write-entry struct `{addr, rgb}`.
- Sub-module `ycc_wr_fifo`: a synchronous FIFO with first-word-fall-through output and full/empty flags. All other logic is inline.

## Test plan
- **Reset values:** reset, then `enable`=1 and `frame_start`. Expect `cv_*`=64/512/512 while no pixel is presented, `busy`=1 and `wr_valid`=0.
- **Single pixel latency:** with `wr_ready`=1, push Y=940, Cr=Cb=512 at (0,0). Expect `wr_valid` 4 clocks later with `wr_addr`=0 and `wr_data`=24'hFFFFFF.
- **Line advance:**
  - Run 3 full lines with H_ACTIVE=8, V_ACTIVE=4.
  - Expect the first pixel of line 2 at address 16.
  - Pixels beyond x=7 are ignored, with no change to `drop_cnt`.
- **Back-pressure and overflow:**
  - Hold `wr_ready`=0 and push 10 pixels with FIFO_DEPTH=4. Expect `drop_cnt`=6 and `overflow`=1.
  - Release `wr_ready`. Expect 4 writes, at addresses 0–3, in order.
- **End of frame and mid-frame restart:**
  - A full frame ends with FLUSH, then `frame_done` one clock after the last write, then IDLE.
  - A `frame_start` issued mid-frame completes the in-flight writes and resets the address to 0.
- **Mid-frame reset:** assert `rst` while the FIFO is non-empty. Expect `wr_valid`=0 on the next clock and no further writes.

Source files
------------

// File: rtl/ycc_stream_ctrl_pkg.sv
// Shared state encoding, black-level constants and FIFO entry layout for the YCbCr capture sequencer.
// Pure declarations: no latency, no backpressure.
package ycc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } ycc_state_t;

    localparam logic [9:0] YCC_BLACK_Y  = 10'd64;
    localparam logic [9:0] YCC_BLACK_C  = 10'd512;
    localparam int         CONV_LAT_DEF = 3;
    localparam int         YCC_ADDR_W   = 19;

    typedef struct packed {
        logic [YCC_ADDR_W-1:0] addr;
        logic [23:0]           rgb;
    } ycc_wr_entry_t;

endpackage

// File: rtl/ycc_stream_ctrl_if.sv
// Pixel-in, converter and frame-buffer write bundle; master is the sequencer side.
// Wires only: no latency; the wr_* group uses valid/ready.
interface ycc_stream_ctrl_if #(
    parameter int ADDR_W = 19
);
    logic              frame_start;
    logic              line_start;
    logic              pix_valid;
    logic [9:0]        pix_y;
    logic [9:0]        pix_cr;
    logic [9:0]        pix_cb;
    logic [9:0]        cv_y;
    logic [9:0]        cv_cr;
    logic [9:0]        cv_cb;
    logic [7:0]        cv_r;
    logic [7:0]        cv_g;
    logic [7:0]        cv_b;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;

    modport master (
        input  frame_start, line_start, pix_valid, pix_y, pix_cr, pix_cb,
        output cv_y, cv_cr, cv_cb,
        input  cv_r, cv_g, cv_b,
        output wr_valid, wr_addr, wr_data,
        input  wr_ready
    );

    modport slave (
        output frame_start, line_start, pix_valid, pix_y, pix_cr, pix_cb,
        input  cv_y, cv_cr, cv_cb,
        output cv_r, cv_g, cv_b,
        input  wr_valid, wr_addr, wr_data,
        output wr_ready
    );
endinterface

// File: rtl/ycc_stream_ctrl_wr_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags; dout shows the head while empty is low.
// Zero read latency; a push while full is taken only if a pop happens in the same cycle, otherwise it is discarded.
module ycc_wr_fifo #(
    parameter int WIDTH = 43,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int           AW      = $clog2(DEPTH);
    localparam logic [AW:0]  PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit tells full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/ycc_stream_ctrl.sv
// Capture sequencer: tracks active-window x/y, drives the YCbCr->RGB converter and queues frame-buffer writes.
// Pixel to wr_valid is CONV_LAT+1 clocks; input is never stalled, so a push into a full FIFO is dropped and counted.
module ycc_stream_ctrl
    import ycc_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int CONV_LAT   = CONV_LAT_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = YCC_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    ycc_stream_ctrl_if.master bus,
    output logic              frame_done,
    output logic              overflow,
    output logic [15:0]       drop_cnt,
    output logic              busy
);
    localparam int                XW       = $clog2(H_ACTIVE + 1);
    localparam int                YW       = $clog2(V_ACTIVE + 1);
    localparam logic [XW-1:0]     X_END    = XW'(H_ACTIVE);
    localparam logic [XW-1:0]     X_LAST   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0]     Y_END    = YW'(V_ACTIVE);
    localparam logic [YW-1:0]     Y_LAST   = YW'(V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_ACTIVE);

    ycc_state_t          state;
    ycc_state_t          state_nxt;
    logic [XW-1:0]       x;
    logic [YW-1:0]       y;
    logic [ADDR_W-1:0]   row_base;
    logic [ADDR_W-1:0]   pix_addr;
    logic                accept;
    logic                last_pix;
    logic                restart;
    logic                sb_vld;
    logic [ADDR_W-1:0]   sb_addr;
    logic [CONV_LAT-1:0] dl_vld;
    logic [ADDR_W-1:0]   dl_addr [CONV_LAT];
    ycc_wr_entry_t       push_entry;
    ycc_wr_entry_t       head_entry;
    logic                push;
    logic                pop;
    logic                drop;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pipe_empty;

    assign accept   = (state == ST_ACTIVE) && bus.pix_valid && (x < X_END) && (y < Y_END);
    assign last_pix = accept && (x == X_LAST) && (y == Y_LAST);
    assign restart  = bus.frame_start && ((state == ST_ACTIVE) || ((state == ST_IDLE) && enable));
    assign pix_addr = row_base + ADDR_W'(x);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (enable && bus.frame_start) state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (last_pix) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (pipe_empty && fifo_empty) begin
                    state_nxt  = ST_IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Row base advances by a line at a time so the address never needs a multiply.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            x        <= '0;
            y        <= '0;
            row_base <= '0;
        end else if ((state == ST_ACTIVE) && bus.line_start) begin
            x <= '0;
            if ((x != '0) && (y < Y_END)) begin
                y        <= y + YW'(1);
                row_base <= row_base + ROW_STEP;
            end
        end else if (accept) begin
            x <= x + XW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.cv_y  <= YCC_BLACK_Y;
            bus.cv_cr <= YCC_BLACK_C;
            bus.cv_cb <= YCC_BLACK_C;
            sb_vld    <= 1'b0;
            sb_addr   <= '0;
        end else begin
            bus.cv_y  <= accept ? bus.pix_y  : YCC_BLACK_Y;
            bus.cv_cr <= accept ? bus.pix_cr : YCC_BLACK_C;
            bus.cv_cb <= accept ? bus.pix_cb : YCC_BLACK_C;
            sb_vld    <= accept;
            sb_addr   <= pix_addr;
        end
    end

    // Sideband trails the converter input register by CONV_LAT clocks, landing alongside cv_r/g/b.
    always_ff @(posedge clk) begin
        if (rst) begin
            dl_vld <= '0;
            for (int i = 0; i < CONV_LAT; i++) dl_addr[i] <= '0;
        end else begin
            dl_vld[0]  <= sb_vld;
            dl_addr[0] <= sb_addr;
            for (int i = 1; i < CONV_LAT; i++) begin
                dl_vld[i]  <= dl_vld[i-1];
                dl_addr[i] <= dl_addr[i-1];
            end
        end
    end

    assign pipe_empty = !sb_vld && (dl_vld == '0);
    assign push       = dl_vld[CONV_LAT-1];
    assign push_entry = {YCC_ADDR_W'(dl_addr[CONV_LAT-1]), bus.cv_r, bus.cv_g, bus.cv_b};
    assign pop        = !fifo_empty && bus.wr_ready;
    assign drop       = push && fifo_full && !pop;

    ycc_wr_fifo #(
        .WIDTH ($bits(ycc_wr_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.wr_valid = !fifo_empty;
    assign bus.wr_addr  = fifo_empty ? '0 : ADDR_W'(head_entry.addr);
    assign bus.wr_data  = fifo_empty ? '0 : head_entry.rgb;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (drop)                  overflow <= 1'b1;
            else if (bus.frame_start)  overflow <= 1'b0;
            if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
        end
    end
endmodule
